// File: rtl/ledpanel_pkg.sv
// Shared types and defaults for the LED panel scan controller.
// Holds the scan FSM state enum and the frame memory address composer.
package ledpanel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_TOP,
    ADDR_BOT,
    SETUP,
    CLK_HI,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int DEF_ADDR_LINES = 10;
  localparam int DEF_COLOR_BITS = 8;
  localparam int DEF_ROW_BITS   = 4;
  localparam int DEF_COL_BITS   = 5;
  localparam int DEF_BASE_TICKS = 4;

  // Frame memory address layout is {half, row, col}.
  function automatic logic [31:0] compose_addr(input logic        half,
                                               input logic [15:0] row,
                                               input logic [15:0] col,
                                               input int          row_bits,
                                               input int          col_bits);
    logic [31:0] addr;
    addr = (32'(half) << (row_bits + col_bits)) | (32'(row) << col_bits) | 32'(col);
    return addr;
  endfunction

endpackage

// File: rtl/ledpanel_bcm_timer.sv
// BCM display window timer: down-counter loaded with BASE_TICKS<<plane at LATCH.
// With LEDPANEL_GLOBAL_BRIGHTNESS_EN defined, the on-time is scaled by brightness.
module ledpanel_bcm_timer
  import ledpanel_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int PW         = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          run,
  input  logic [PW-1:0] plane,
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          oe_active,
  output logic          done
);

  localparam int CW = COLOR_BITS + $clog2(BASE_TICKS) + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] thr;
  logic [CW-1:0] win_len;
  logic [CW-1:0] on_len;

  assign win_len = CW'(BASE_TICKS) << plane;

`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
  logic [CW+8:0] on_prod;
  assign on_prod = (CW+9)'(win_len) * (CW+9)'({1'b0, brightness} + 9'd1);
  assign on_len  = CW'(on_prod >> 8);
`else
  assign on_len  = win_len;
`endif

  // thr is the count value below which the LEDs stay dark for the rest of the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      thr <= '0;
    end else if (load) begin
      cnt <= win_len;
      thr <= win_len - on_len;
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done      = run && (cnt == CW'(1));
  assign oe_active = run && (cnt > thr);

endmodule

// File: rtl/ledpanel_scan_controller.sv
// HUB75 1:16 scan controller with binary-coded modulation over COLOR_BITS planes.
// Optional global brightness port: define LEDPANEL_GLOBAL_BRIGHTNESS_EN.
//
// state    | meaning
// IDLE     | not scanning, row/plane retained
// ADDR_TOP | present top-half address
// ADDR_BOT | present bottom-half address, capture top bits
// SETUP    | capture bottom bits, panel_clk low
// CLK_HI   | panel_clk high, advance column
// BLANK    | outputs off before latch
// LATCH    | latch strobe, update row select
// DISPLAY  | LEDs on for the plane-weighted window
module ledpanel_scan_controller
  import ledpanel_pkg::*;
#(
  parameter int ADDR_LINES = DEF_ADDR_LINES,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int COL_BITS   = DEF_COL_BITS,
  parameter int BASE_TICKS = DEF_BASE_TICKS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scan_enable,
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
  input  logic [7:0]            brightness,
`endif
  output logic [ADDR_LINES-1:0] mem_addr,
  input  logic [COLOR_BITS-1:0] mem_red,
  input  logic [COLOR_BITS-1:0] mem_green,
  input  logic [COLOR_BITS-1:0] mem_blue,
  output logic                  panel_r1,
  output logic                  panel_g1,
  output logic                  panel_b1,
  output logic                  panel_r2,
  output logic                  panel_g2,
  output logic                  panel_b2,
  output logic                  panel_clk,
  output logic                  panel_lat,
  output logic                  panel_oe_n,
  output logic [ROW_BITS-1:0]   panel_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST   = '1;
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;
  localparam logic [PW-1:0]       PLANE_LAST = PW'(COLOR_BITS - 1);

  scan_state_t         state, state_nx;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [PW-1:0]       plane;
  logic                addr_half;
  logic                oe_active;
  logic                disp_done;

  ledpanel_bcm_timer #(
    .COLOR_BITS (COLOR_BITS),
    .BASE_TICKS (BASE_TICKS),
    .PW         (PW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (state == LATCH),
    .run        (state == DISPLAY),
    .plane      (plane),
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .oe_active  (oe_active),
    .done       (disp_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (scan_enable) state_nx = ADDR_TOP;
      ADDR_TOP: state_nx = ADDR_BOT;
      ADDR_BOT: state_nx = SETUP;
      SETUP:    state_nx = CLK_HI;
      CLK_HI:   state_nx = (col == COL_LAST) ? BLANK : ADDR_TOP;
      BLANK:    state_nx = LATCH;
      LATCH:    state_nx = DISPLAY;
      DISPLAY:  if (disp_done) state_nx = scan_enable ? ADDR_TOP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      plane      <= '0;
      panel_r1   <= 1'b0;
      panel_g1   <= 1'b0;
      panel_b1   <= 1'b0;
      panel_r2   <= 1'b0;
      panel_g2   <= 1'b0;
      panel_b2   <= 1'b0;
      panel_row  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      case (state)
        ADDR_BOT: begin
          panel_r1 <= mem_red[plane];
          panel_g1 <= mem_green[plane];
          panel_b1 <= mem_blue[plane];
        end
        SETUP: begin
          panel_r2 <= mem_red[plane];
          panel_g2 <= mem_green[plane];
          panel_b2 <= mem_blue[plane];
        end
        CLK_HI:  col <= col + 1'b1;
        LATCH:   panel_row <= row;
        DISPLAY: begin
          if (disp_done) begin
            if (plane == PLANE_LAST) begin
              plane      <= '0;
              row        <= row + 1'b1;
              frame_done <= (row == ROW_LAST);
            end else begin
              plane <= plane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Half bit stays set through CLK_HI so the address only changes once per half.
  assign addr_half  = (state == ADDR_BOT) || (state == SETUP) || (state == CLK_HI);
  assign mem_addr   = ADDR_LINES'(compose_addr(addr_half, 16'(row), 16'(col), ROW_BITS, COL_BITS));
  assign panel_clk  = (state == CLK_HI);
  assign panel_lat  = (state == LATCH);
  assign panel_oe_n = !((state == DISPLAY) && oe_active);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ledpanel_scan_controller.sv
// Self-checking bench for ledpanel_scan_controller: plane table, shift scoreboard, corner sequences.
module tb_ledpanel_scan_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scan_enable = 1'b0;
  logic [9:0] mem_addr;
  logic [7:0] mem_red, mem_green, mem_blue;
  logic       panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
  logic       panel_clk, panel_lat, panel_oe_n;
  logic [3:0] panel_row;
  logic       busy, frame_done;
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  ledpanel_scan_controller dut (
    .clock       (clock),
    .reset       (reset),
    .scan_enable (scan_enable),
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .mem_addr    (mem_addr),
    .mem_red     (mem_red),
    .mem_green   (mem_green),
    .mem_blue    (mem_blue),
    .panel_r1    (panel_r1),
    .panel_g1    (panel_g1),
    .panel_b1    (panel_b1),
    .panel_r2    (panel_r2),
    .panel_g2    (panel_g2),
    .panel_b2    (panel_b2),
    .panel_clk   (panel_clk),
    .panel_lat   (panel_lat),
    .panel_oe_n  (panel_oe_n),
    .panel_row   (panel_row),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  // Frame memory model: registered read, contents derived from the address.
  function automatic logic [23:0] mem_word(input logic [9:0] a);
    return {a[7:0], a[8:1], a[9:2]};
  endfunction

  always @(posedge clock) {mem_red, mem_green, mem_blue} <= mem_word(mem_addr);

  function automatic logic [5:0] exp_bits(input logic [9:0] top, input logic [9:0] bot, input int p);
    logic [23:0] wt, wb;
    wt = mem_word(top);
    wb = mem_word(bot);
    return {wt[16+p], wt[8+p], wt[p], wb[16+p], wb[8+p], wb[p]};
  endfunction

  typedef struct {
    int plane;
    int bright;
    int exp_oe;
    int exp_int;
  } vec_t;

  vec_t       tbl[8];
  int         n_pass = 0;
  int         n_total = 0;
  logic [9:0] prev_addr = '0;
  logic       prev_clk = 1'b0;
  logic       prev_lat = 1'b0;
  logic       clk_rise = 1'b0;
  logic [5:0] exp_q[$];
  logic [9:0] addr_log[$];
  bit         log_on = 1'b0;
  int         sb_plane = 0;
  int         fd_cnt = 0;
  int         fd_w = 0;
  int         fd_max = 0;
  int         lat_oe_bad = 0;
  int         last_row = -1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock, sampled at the falling edge, with the scoreboard and monitors.
  task automatic step();
    @(negedge clock);
    clk_rise = panel_clk && !prev_clk;
    if (!reset) begin
      if (mem_addr[9] && !prev_addr[9] && mem_addr[8:0] == prev_addr[8:0])
        exp_q.push_back(exp_bits(prev_addr, mem_addr, sb_plane));
      if (clk_rise) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: panel_clk edge with no expected column");
        end else begin
          check("shift_bits", int'({panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2}),
                int'(exp_q.pop_front()));
        end
      end
      if (panel_lat) begin
        sb_plane = (sb_plane + 1) % 8;
        if (panel_oe_n !== 1'b1) lat_oe_bad++;
      end
      if (prev_lat) last_row = int'(panel_row);
      if (log_on && mem_addr !== prev_addr && addr_log.size() < 62) addr_log.push_back(mem_addr);
      if (frame_done) begin
        fd_cnt++;
        fd_w++;
        if (fd_w > fd_max) fd_max = fd_w;
      end else begin
        fd_w = 0;
      end
    end
    prev_addr = mem_addr;
    prev_clk  = panel_clk;
    prev_lat  = panel_lat;
  endtask

  task automatic wait_lat(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!panel_lat && n < budget);
    if (!panel_lat) begin
      n_total++;
      $display("FAIL wait_lat: no latch within %0d clocks", budget);
    end
  endtask

  // Called on a latch cycle; runs up to the next latch.
  task automatic measure(output int oe_low, output int interval, output int clks, output int row_after);
    oe_low = 0;
    interval = 0;
    clks = 0;
    row_after = -1;
    do begin
      step();
      interval++;
      if (interval == 1) row_after = int'(panel_row);
      if (!panel_oe_n) oe_low++;
      if (clk_rise) clks++;
    end while (!panel_lat && interval < 2000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_low, interval, clks, row_after, n, k, lats;
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
    tbl[0] = '{plane: 0, bright: 0,   exp_oe: 0,   exp_int: 134};
    tbl[1] = '{plane: 1, bright: 127, exp_oe: 4,   exp_int: 138};
    tbl[2] = '{plane: 2, bright: 127, exp_oe: 8,   exp_int: 146};
    tbl[3] = '{plane: 3, bright: 255, exp_oe: 32,  exp_int: 162};
    tbl[4] = '{plane: 4, bright: 63,  exp_oe: 16,  exp_int: 194};
    tbl[5] = '{plane: 5, bright: 255, exp_oe: 128, exp_int: 258};
    tbl[6] = '{plane: 6, bright: 191, exp_oe: 192, exp_int: 386};
    tbl[7] = '{plane: 7, bright: 255, exp_oe: 512, exp_int: 642};
`else
    tbl[0] = '{plane: 0, bright: 255, exp_oe: 4,   exp_int: 134};
    tbl[1] = '{plane: 1, bright: 255, exp_oe: 8,   exp_int: 138};
    tbl[2] = '{plane: 2, bright: 255, exp_oe: 16,  exp_int: 146};
    tbl[3] = '{plane: 3, bright: 255, exp_oe: 32,  exp_int: 162};
    tbl[4] = '{plane: 4, bright: 255, exp_oe: 64,  exp_int: 194};
    tbl[5] = '{plane: 5, bright: 255, exp_oe: 128, exp_int: 258};
    tbl[6] = '{plane: 6, bright: 255, exp_oe: 256, exp_int: 386};
    tbl[7] = '{plane: 7, bright: 255, exp_oe: 512, exp_int: 642};
`endif

    // Reset values
    repeat (3) step();
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_data", int'({panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2}), 0);
    check("rst_clk", int'(panel_clk), 0);
    check("rst_lat", int'(panel_lat), 0);
    check("rst_oe_n", int'(panel_oe_n), 1);
    check("rst_row", int'(panel_row), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    repeat (4) step();
    check("idle_busy", int'(busy), 0);

    // Row 0: address sequence and per-plane timing table
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
    brightness = 8'(tbl[0].bright);
`endif
    log_on = 1'b1;
    scan_enable = 1'b1;
    step();
    check("first_addr", int'(mem_addr), 0);
    check("start_busy", int'(busy), 1);
    wait_lat(200);
    log_on = 1'b0;
    check("addr_log_len", addr_log.size(), 62);
    for (int i = 0; i < addr_log.size(); i++)
      check($sformatf("addr_seq_%0d", i), int'(addr_log[i]), (i % 2 == 0) ? 32'h200 + i / 2 : (i + 1) / 2);
    for (int i = 0; i < 8; i++) begin
`ifdef LEDPANEL_GLOBAL_BRIGHTNESS_EN
      brightness = (i < 7) ? 8'(tbl[i+1].bright) : 8'd255;
`endif
      measure(oe_low, interval, clks, row_after);
      check($sformatf("oe_low_p%0d", tbl[i].plane), oe_low, tbl[i].exp_oe);
      check($sformatf("interval_p%0d", tbl[i].plane), interval, tbl[i].exp_int);
      check($sformatf("clk_edges_after_p%0d", tbl[i].plane), clks, 32);
      check($sformatf("row_p%0d", tbl[i].plane), row_after, 0);
    end

    // Frame wrap
    n = 0;
    while (fd_cnt == 0 && n < 40000) begin
      step();
      n++;
    end
    check("frame_done_seen", fd_cnt, 1);
    check("row_before_wrap", last_row, 15);
    repeat (4) step();
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_width", fd_max, 1);
    wait_lat(300);
    measure(oe_low, interval, clks, row_after);
    check("wrap_row", row_after, 0);
    check("wrap_plane0_oe", oe_low, 4);

    // Enable drop during column 10 of row 3, plane 2
    repeat (24) wait_lat(1200);
    n = 0;
    k = 0;
    while (k < 10 && n < 400) begin
      step();
      n++;
      if (clk_rise) k++;
    end
    scan_enable = 1'b0;
    n = 0;
    clks = 0;
    lats = 0;
    oe_low = 0;
    while (busy && n < 500) begin
      step();
      n++;
      if (clk_rise) clks++;
      if (panel_lat) lats++;
      if (!panel_oe_n) oe_low++;
    end
    check("drop_remaining_clks", clks, 22);
    check("drop_latches", lats, 1);
    check("drop_oe_low", oe_low, 16);
    check("drop_idle", int'(busy), 0);
    check("drop_row", last_row, 3);
    repeat (10) step();
    check("drop_stay_idle", int'(busy), 0);
    check("drop_oe_off", int'(panel_oe_n), 1);
    scan_enable = 1'b1;
    step();
    check("resume_addr", int'(mem_addr), 32'h060);
    wait_lat(300);
    measure(oe_low, interval, clks, row_after);
    check("resume_row", row_after, 3);
    check("resume_plane3_oe", oe_low, 32);

    // Reset at clock 20 of the plane-4 window
    n = 0;
    while (panel_oe_n && n < 10) begin
      step();
      n++;
    end
    repeat (19) step();
    check("pre_reset_oe_n", int'(panel_oe_n), 0);
    reset = 1'b1;
    step();
    check("mid_reset_oe_n", int'(panel_oe_n), 1);
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_row", int'(panel_row), 0);
    exp_q.delete();
    sb_plane = 0;
    reset = 1'b0;
    step();
    check("post_reset_busy", int'(busy), 1);
    check("post_reset_addr", int'(mem_addr), 0);
    wait_lat(300);
    measure(oe_low, interval, clks, row_after);
    check("post_reset_row", row_after, 0);
    check("post_reset_oe", oe_low, 4);

    check("lat_implies_oe_off", lat_oe_bad, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ledpanel_scan_controller.md
Name: ledpanel_scan_controller

Overview:
- Sequences the read port of the LED panel frame memory (registered RGB outputs, already gamma-corrected) and drives a HUB75-style 1:16 scan panel.
- Uses binary-coded modulation (BCM). For each scan row and each colour bit-plane it:
  - shifts out COLUMNS column pairs, one pixel from the top half and one from the bottom half;
  - latches the shifted data;
  - enables the LEDs for a time weighted by the plane number.
- Sits between the frame/gamma memory and the panel connector pins.

Parameters:
- ADDR_LINES, 10, frame memory address width; must equal 1 + ROW_BITS + COL_BITS.
- COLOR_BITS, 8, bits per colour channel; equals the number of BCM planes.
- ROW_BITS, 4, scan row address width (16 rows per half).
- COL_BITS, 5, column index width; COLUMNS = 1<<COL_BITS.
- BASE_TICKS, 4, display clocks for plane 0; power of two, at least 1.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- scan_enable  in  1  start/continue scanning
- mem_addr  out  ADDR_LINES  read address to the frame memory, laid out as {half,row,col}
- mem_red  in  COLOR_BITS  memory red output, valid 1 clock after mem_addr
- mem_green  in  COLOR_BITS  memory green output, same timing
- mem_blue  in  COLOR_BITS  memory blue output, same timing
- panel_r1, panel_g1, panel_b1  out  1 each  top-half data bits
- panel_r2, panel_g2, panel_b2  out  1 each  bottom-half data bits
- panel_clk  out  1  shift clock
- panel_lat  out  1  latch strobe
- panel_oe_n  out  1  output enable, active low
- panel_row  out  ROW_BITS  row select
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-clock pulse at the end of each full frame

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset state: state IDLE, row=0, plane=0, col=0.
- Reset output values:
  - mem_addr=0, all six panel data bits=0;
  - panel_clk=0, panel_lat=0, panel_oe_n=1;
  - panel_row=0, busy=0, frame_done=0.
- Reset mid-operation: abandons the scan immediately; panel_oe_n is 1 on the clock after reset is sampled.
- FSM states: IDLE, ADDR_TOP, ADDR_BOT, SETUP, CLK_HI, BLANK, LATCH, DISPLAY.
- Column cycle (4 clocks per column):
  - ADDR_TOP: mem_addr={0,row,col}.
  - ADDR_BOT: mem_addr={1,row,col}; capture the top-half bit plane of mem_* into the r1/g1/b1 registers.
  - SETUP: capture the bottom-half bit plane into r2/g2/b2; panel_clk=0.
  - CLK_HI: panel_clk=1. If col==COLUMNS-1, go to BLANK; otherwise col++ and go to ADDR_TOP.
  - The captured bit is mem_x[plane].
- Panel data: panel_r1..b2 change only in ADDR_BOT/SETUP, and hold stable through CLK_HI.
- BLANK (1 clock): panel_oe_n=1.
- LATCH (1 clock): panel_lat=1, panel_row<=row, panel_oe_n=1.
- DISPLAY:
  - panel_oe_n=0 for exactly L = BASE_TICKS<<plane clocks.
  - Counter width is COLOR_BITS+$clog2(BASE_TICKS)+1 bits; it never wraps.
- End of DISPLAY:
  - If plane<COLOR_BITS-1: plane++.
  - Otherwise plane=0 and row++. Row wraps from (1<<ROW_BITS)-1 to 0, and on that wrap frame_done=1 for one clock.
- Plane duration: COLUMNS*4 + 2 + L clocks.
- IDLE:
  - Leave IDLE to ADDR_TOP (col=0) when scan_enable=1.
  - Re-entering IDLE keeps row and plane, so scanning resumes where it stopped.
- scan_enable dropping to 0 outside IDLE:
  - The current plane completes, including DISPLAY.
  - The FSM then enters IDLE with panel_oe_n=1.
- Simultaneous row wrap and scan_enable=0: frame_done still pulses, then the FSM goes to IDLE.
- panel_lat and panel_oe_n are never low-and-high together: panel_lat=1 implies panel_oe_n=1.

Optional Feature:
- Macro: LEDPANEL_GLOBAL_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [7:0].
  - brightness is sampled at LATCH.
  - In DISPLAY, panel_oe_n=0 only for the first (L*(brightness+1))>>8 clocks of the L-clock window; the window length is unchanged.
  - brightness=255 gives full on-time.
- Undefined: no brightness port; panel_oe_n=0 for all L clocks.

Decomposition:
- Package ledpanel_pkg contains:
  - the FSM state enum;
  - default parameter constants;
  - an address-compose function {half,row,col}.
- Sub-module ledpanel_bcm_timer:
  - loads L from plane and BASE_TICKS;
  - counts the DISPLAY window;
  - produces oe_active and done, including the brightness compare under the macro.

Test Plan:
- Reset mid-DISPLAY:
  - Stimulus: assert reset at clock 20 of a 64-clock window.
  - Required: next clock panel_oe_n=1, busy=0, panel_row=0; after release with scan_enable=1, the first mem_addr is 0x000.
- Shift content:
  - Stimulus: memory word = address pattern, plane 0, row 0.
  - Required: 32 panel_clk rising edges; at column c, r1=bit0 of the top word and r2=bit0 of the word at 0x200+c.
  - Required: mem_addr sequence is 0x000, 0x200, 0x001, 0x201, and so on.
- Plane timing:
  - Required: plane 0 has panel_oe_n low for 4 clocks; plane 7 has it low for 512 clocks.
  - Required: plane 0 total duration = 128+2+4 = 134 clocks.
- Frame wrap:
  - Stimulus: run through row 15, plane 7.
  - Required: frame_done is high for exactly 1 clock.
  - Required: the next latch sets panel_row=0, and the next plane is plane 0.
- Enable drop:
  - Stimulus: drop scan_enable during column 10 of row 3, plane 2.
  - Required: the shift completes, the latch occurs, oe_n is low for 16 clocks, then IDLE.
  - Required: re-enabling resumes at row 3, plane 3.
- Brightness (macro defined):
  - Stimulus: brightness=127, plane 2 (L=16).
  - Required: oe_n low for 8 clocks, then high for 8 clocks.
  - Stimulus: brightness=0, plane 0.
  - Required: oe_n low for 0 clocks.
